// File: rtl/sel_mux_rr_pkg.sv
// sel_mux_rr_pkg: shared defaults and mode encodings for the selector
package sel_mux_rr_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int MUX_N = 8;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/sel_mux_rr_rr_pick.sv
// sel_mux_rr_rr_pick: rotating-priority search starting at ptr
module sel_mux_rr_rr_pick
  import sel_mux_rr_pkg::*;
#(
  parameter int N = MUX_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  // walk from the farthest offset down so the nearest request to ptr wins
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx = SEL_W'((int'(ptr) + k) % N);
        gnt_vld = 1'b1;
      end
  end
endmodule

// File: rtl/sel_mux_rr.sv
// sel_mux_rr: N:1 registered selector with direct or round-robin arbitration
module sel_mux_rr
  import sel_mux_rr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N = MUX_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]    out_src,
  output logic                out_valid,
  input  logic                out_ready
);
  logic [SEL_W-1:0] rr_ptr, rr_idx, g;
  logic rr_vld, d_vld, gv, load, xfer;
  sel_mux_rr_rr_pick #(.N(N)) u_pick (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );
  assign d_vld = (int'(sel) < N) && in_valid[sel];
  assign g = (mode == MODE_RR) ? rr_idx : sel;
  assign gv = (mode == MODE_RR) ? rr_vld : d_vld;
  assign load = ~out_valid | out_ready;
  assign xfer = load & gv;
  assign in_ready = xfer ? N'(1) << g : '0;
  // output register and round-robin pointer; a drained slot with no grant just empties
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      out_src <= '0;
      out_valid <= 1'b0;
      rr_ptr <= '0;
    end else if (xfer) begin
      out_data <= in_data[g*DATA_W +: DATA_W];
      out_src <= g;
      out_valid <= 1'b1;
      if (mode == MODE_RR) rr_ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_sel_mux_rr.sv
// tb_sel_mux_rr: vector table, corner sequences and randomized model check
module tb_sel_mux_rr;
  localparam int N = 8;
  localparam int W = 32;
  logic clk = 0, rst;
  logic mode, out_ready, out_valid;
  logic [2:0] sel, out_src;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_ready;
  logic [W-1:0] out_data;
  logic u_mode, u_ordy, u_ov;
  logic [2:0] u_sel, u_src;
  logic [6*W-1:0] u_data;
  logic [5:0] u_valid, u_ready;
  logic [W-1:0] u_odata;
  int checks = 0, errors = 0;
  bit m_valid;
  int m_src, m_ptr;
  logic [W-1:0] m_data;
  logic [N-1:0] rdy_seen;

  sel_mux_rr dut (.clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready));
  sel_mux_rr #(.N(6)) dut6 (.clk(clk), .rst(rst), .mode(u_mode), .sel(u_sel), .in_data(u_data),
    .in_valid(u_valid), .in_ready(u_ready), .out_data(u_odata), .out_src(u_src),
    .out_valid(u_ov), .out_ready(u_ordy));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] v;
    logic [7:0] exp_rdy;
    bit exp_ov;
    int exp_src;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference grant: list channels in rotated order, keep those requesting, take the head
  function automatic int exp_grant(bit md, int s, logic [N-1:0] v, int ptr);
    int q[$];
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) q.push_back((ptr + k) % N);
    return q.size() ? q[0] : -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_src = 0; m_ptr = 0; m_data = 0;
  endtask

  task automatic tick();
    int g;
    bit ld;
    logic [W-1:0] d;
    #1;
    ld = !m_valid || out_ready;
    g = exp_grant(mode, int'(sel), in_valid, m_ptr);
    rdy_seen = in_ready;
    chk("in_ready", {56'd0, in_ready}, (ld && g >= 0) ? (64'd1 << g) : 64'd0);
    d = (g >= 0) ? in_data[g*W +: W] : '0;
    @(posedge clk);
    if (ld && g >= 0) begin
      m_data = d; m_src = g; m_valid = 1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) m_valid = 0;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_src", {61'd0, out_src}, m_src);
    chk("out_data", {32'd0, out_data}, {32'd0, m_data});
  endtask

  task automatic fixed_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hDEAD_0000 | i;
  endtask

  task automatic set(bit md, int s, logic [7:0] v, bit r);
    mode = md; sel = s[2:0]; in_valid = v; out_ready = r;
  endtask

  initial begin
    logic [W-1:0] hd;
    tbl[0] = '{3'd3, 8'hFF, 8'h08, 1, 3};
    tbl[1] = '{3'd0, 8'h01, 8'h01, 1, 0};
    tbl[2] = '{3'd7, 8'h80, 8'h80, 1, 7};
    tbl[3] = '{3'd5, 8'hDF, 8'h00, 0, 7};
    tbl[4] = '{3'd2, 8'h04, 8'h04, 1, 2};
    rst = 1; set(0, 0, 0, 0); in_data = '0;
    u_mode = 0; u_sel = 0; u_valid = 0; u_ordy = 1; u_data = '0;
    model_reset();
    fixed_data();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_valid", {63'd0, out_valid}, 0);
    chk("reset_data", {32'd0, out_data}, 0);
    chk("reset_src", {61'd0, out_src}, 0);
    rst = 0;
    // direct-mode vectors
    for (int i = 0; i < 5; i++) begin
      set(0, tbl[i].sel, tbl[i].v, 1);
      tick();
      chk($sformatf("tbl%0d_rdy", i), {56'd0, rdy_seen}, {56'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_ov", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_src", i), {61'd0, out_src}, tbl[i].exp_src);
    end
    chk("tbl_data", {32'd0, out_data}, 64'hDEAD_0002);
    // move rr_ptr away from 0, then reset asynchronously mid-stream
    set(1, 0, 8'hFF, 1);
    repeat (3) tick();
    #2 rst = 1;
    #1;
    chk("async_valid", {63'd0, out_valid}, 0);
    chk("async_data", {32'd0, out_data}, 0);
    chk("async_src", {61'd0, out_src}, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    // round-robin with all channels requesting
    set(1, 0, 8'hFF, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rr_seq_src", {61'd0, out_src}, k % 8);
      chk("rr_seq_valid", {63'd0, out_valid}, 1);
    end
    // wrap from rr_ptr=6
    set(1, 0, 8'h20, 1);
    tick();
    chk("wrap_setup", {61'd0, out_src}, 5);
    set(1, 0, 8'h21, 1);
    tick();
    chk("wrap_g0", {61'd0, out_src}, 0);
    tick();
    chk("wrap_g5", {61'd0, out_src}, 5);
    // backpressure holds everything
    set(0, 5, 8'h20, 1);
    tick();
    hd = out_data;
    set(0, 2, 8'hFF, 0);
    repeat (3) begin
      tick();
      chk("bp_rdy", {56'd0, rdy_seen}, 0);
      chk("bp_src", {61'd0, out_src}, 5);
      chk("bp_data", {32'd0, out_data}, {32'd0, hd});
    end
    set(0, 2, 8'h04, 1);
    tick();
    chk("bp_release_rdy", {56'd0, rdy_seen}, 8'h04);
    chk("bp_release_src", {61'd0, out_src}, 2);
    chk("bp_release_data", {32'd0, out_data}, 64'hDEAD_0002);
    // six-channel instance: out-of-range and idle selections
    for (int i = 0; i < 6; i++) u_data[i*W +: W] = 32'hBEEF_0000 | i;
    u_sel = 3'd7; u_valid = 6'h3F;
    #1 chk("n6_sel7_rdy", {58'd0, u_ready}, 0);
    @(posedge clk); #1 chk("n6_sel7_ov", {63'd0, u_ov}, 0);
    u_sel = 3'd5; u_valid = 6'h1F;
    #1 chk("n6_sel5_rdy", {58'd0, u_ready}, 0);
    @(posedge clk); #1 chk("n6_sel5_ov", {63'd0, u_ov}, 0);
    u_sel = 3'd4;
    #1 chk("n6_sel4_rdy", {58'd0, u_ready}, 6'h10);
    @(posedge clk); #1;
    chk("n6_sel4_src", {61'd0, u_src}, 4);
    chk("n6_sel4_data", {32'd0, u_odata}, 64'hBEEF_0004);
    u_valid = 0;
    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      set($urandom_range(0, 1), $urandom_range(0, 7),
          ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 3) != 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
